// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - coin codes, coin values, payout state enum and item codes shared with the vending core
package vending_pkg;

   localparam logic [2:0] COIN_NONE = 3'd0;
   localparam logic [2:0] COIN_RS1  = 3'd1;
   localparam logic [2:0] COIN_RS2  = 3'd2;
   localparam logic [2:0] COIN_RS5  = 3'd3;
   localparam logic [2:0] COIN_RS10 = 3'd4;

   localparam logic [4:0] VAL_RS1  = 5'd1;
   localparam logic [4:0] VAL_RS2  = 5'd2;
   localparam logic [4:0] VAL_RS5  = 5'd5;
   localparam logic [4:0] VAL_RS10 = 5'd10;

   localparam logic [3:0] ITEM_NONE  = 4'd0;
   localparam logic [3:0] ITEM_WATER = 4'd1;
   localparam logic [3:0] ITEM_SODA  = 4'd2;
   localparam logic [3:0] ITEM_JUICE = 4'd3;
   localparam logic [3:0] ITEM_CHIPS = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_FIRE     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4,
      ST_FAULT    = 3'd5
   } payout_state_t;

   function automatic logic [4:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_RS1:  return VAL_RS1;
         COIN_RS2:  return VAL_RS2;
         COIN_RS5:  return VAL_RS5;
         COIN_RS10: return VAL_RS10;
         default:   return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - four saturating hopper inventory counters with refill and payout ports
module coin_inventory
   import vending_pkg::*;
#(
   parameter int CNT_W     = 6,
   parameter int INIT_RS10 = 8,
   parameter int INIT_RS5  = 8,
   parameter int INIT_RS2  = 8,
   parameter int INIT_RS1  = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_en_i,
   input  logic [2:0]       inc_sel_i,
   input  logic             dec_en_i,
   input  logic [2:0]       dec_sel_i,
   output logic [CNT_W-1:0] inv_rs10_o,
   output logic [CNT_W-1:0] inv_rs5_o,
   output logic [CNT_W-1:0] inv_rs2_o,
   output logic [CNT_W-1:0] inv_rs1_o,
   output logic [3:0]       empty_o
);

   // Slot k holds coin code k+1, so empty_o[0] is Rs1 and empty_o[3] is Rs10.
   for (genvar k = 0; k < 4; k++) begin : g_cnt
      localparam int INIT = (k == 0) ? INIT_RS1 : (k == 1) ? INIT_RS2 :
                            (k == 2) ? INIT_RS5 : INIT_RS10;
      logic [CNT_W-1:0] cnt_q;
      logic             inc;
      logic             dec;

      assign inc = inc_en_i && (inc_sel_i == 3'(k + 1));
      assign dec = dec_en_i && (dec_sel_i == 3'(k + 1));

      // A simultaneous refill and payout cancel out.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q <= CNT_W'(INIT);
         end else if (inc && !dec && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end

      assign empty_o[k] = (cnt_q == '0);
   end

   assign inv_rs1_o  = g_cnt[0].cnt_q;
   assign inv_rs2_o  = g_cnt[1].cnt_q;
   assign inv_rs5_o  = g_cnt[2].cnt_q;
   assign inv_rs10_o = g_cnt[3].cnt_q;

endmodule

// File: rtl/change_payout_sequencer.sv
// rtl/change_payout_sequencer.sv - greedy coin payout FSM; PAYOUT_TIMEOUT_EN adds the ack timeout and FAULT state
module change_payout_sequencer
   import vending_pkg::*;
#(
   parameter int CNT_W     = 6,
   parameter int INIT_RS10 = 8,
   parameter int INIT_RS5  = 8,
   parameter int INIT_RS2  = 8,
   parameter int INIT_RS1  = 8
`ifdef PAYOUT_TIMEOUT_EN
   , parameter int ACK_TIMEOUT = 15
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [4:0]       req_amount,
   output logic             req_ready,
   output logic             hopper_fire,
   output logic [2:0]       hopper_sel,
   input  logic             hopper_ack,
   input  logic             refill,
   input  logic [2:0]       refill_sel,
   output logic             busy,
   output logic             done,
   output logic [4:0]       short_amount,
   output logic             fault,
   output logic [CNT_W-1:0] inv_rs10,
   output logic [CNT_W-1:0] inv_rs5,
   output logic [CNT_W-1:0] inv_rs2,
   output logic [CNT_W-1:0] inv_rs1
);

   payout_state_t state_q;
   logic [4:0]    remaining_q;
   logic [2:0]    sel_q;
   logic          fire_q;
   logic          done_q;
   logic [4:0]    short_q;
   logic [2:0]    pick_d;
   logic [4:0]    pay_val;
   logic [3:0]    empty;
   logic          ack_take;

   assign pay_val  = coin_value(sel_q);
   assign ack_take = (state_q == ST_WAIT_ACK) && hopper_ack;

   coin_inventory #(
      .CNT_W     (CNT_W),
      .INIT_RS10 (INIT_RS10),
      .INIT_RS5  (INIT_RS5),
      .INIT_RS2  (INIT_RS2),
      .INIT_RS1  (INIT_RS1)
   ) u_inv (
      .clk_i      (clk),
      .rst_i      (rst),
      .inc_en_i   (refill),
      .inc_sel_i  (refill_sel),
      .dec_en_i   (ack_take),
      .dec_sel_i  (sel_q),
      .inv_rs10_o (inv_rs10),
      .inv_rs5_o  (inv_rs5),
      .inv_rs2_o  (inv_rs2),
      .inv_rs1_o  (inv_rs1),
      .empty_o    (empty)
   );

   // Greedy pick with no backtracking: largest coin that fits and is in stock.
   always_comb begin
      pick_d = COIN_NONE;
      if ((remaining_q >= VAL_RS10) && !empty[3]) begin
         pick_d = COIN_RS10;
      end else if ((remaining_q >= VAL_RS5) && !empty[2]) begin
         pick_d = COIN_RS5;
      end else if ((remaining_q >= VAL_RS2) && !empty[1]) begin
         pick_d = COIN_RS2;
      end else if ((remaining_q >= VAL_RS1) && !empty[0]) begin
         pick_d = COIN_RS1;
      end
   end

`ifdef PAYOUT_TIMEOUT_EN
   localparam int TMR_W = ($clog2(ACK_TIMEOUT) < 1) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   logic [TMR_W-1:0] timer_q;
   logic             fault_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         sel_q       <= COIN_NONE;
         fire_q      <= 1'b0;
         done_q      <= 1'b0;
         short_q     <= '0;
`ifdef PAYOUT_TIMEOUT_EN
         timer_q     <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         fire_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  remaining_q <= req_amount;
                  short_q     <= '0;
                  if (req_amount == 5'd0) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_SELECT;
                  end
               end
            end
            ST_SELECT: begin
               if (pick_d != COIN_NONE) begin
                  sel_q   <= pick_d;
                  fire_q  <= 1'b1;
                  state_q <= ST_FIRE;
               end else begin
                  short_q <= remaining_q;
                  sel_q   <= COIN_NONE;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_FIRE: begin
`ifdef PAYOUT_TIMEOUT_EN
               timer_q <= '0;
`endif
               state_q <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (hopper_ack) begin
                  remaining_q <= remaining_q - pay_val;
                  if (remaining_q == pay_val) begin
                     short_q <= '0;
                     sel_q   <= COIN_NONE;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_SELECT;
                  end
               end
`ifdef PAYOUT_TIMEOUT_EN
               else if (timer_q == TMR_LAST) begin
                  short_q <= remaining_q;
                  fault_q <= 1'b1;
                  state_q <= ST_FAULT;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
`endif
            end
            ST_DONE:  state_q <= ST_IDLE;
            ST_FAULT: state_q <= ST_FAULT;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign hopper_fire  = fire_q;
   assign hopper_sel   = sel_q;
   assign done         = done_q;
   assign short_amount = short_q;
`ifdef PAYOUT_TIMEOUT_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_payout_sequencer.sv
// tb/tb_change_payout_sequencer.sv - scoreboard bench for change_payout_sequencer (default and sparse-inventory instances)
module tb_change_payout_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid_a, req_valid_b;
   logic [4:0] req_amount;
   logic       tb_ack, rsp_ack, hopper_ack;
   logic       tb_refill, rsp_refill, refill;
   logic [2:0] tb_refill_sel, refill_sel;
   logic       auto_ack, refill_with_ack;
   int         rsp_cnt;

   logic       ready_a, fire_a, busy_a, done_a, fault_a;
   logic [2:0] sel_a;
   logic [4:0] short_a;
   logic [5:0] inv10_a, inv5_a, inv2_a, inv1_a;
   logic       ready_b, fire_b, busy_b, done_b, fault_b;
   logic [2:0] sel_b;
   logic [4:0] short_b;
   logic [5:0] inv10_b, inv5_b, inv2_b, inv1_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_sel_a[$], exp_short_a[$], exp_sel_b[$], exp_short_b[$];

   always #5 clk = ~clk;

   assign hopper_ack = tb_ack | rsp_ack;
   assign refill     = tb_refill | rsp_refill;
   assign refill_sel = rsp_refill ? 3'd3 : tb_refill_sel;

   change_payout_sequencer u_dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_amount(req_amount),
      .req_ready(ready_a), .hopper_fire(fire_a), .hopper_sel(sel_a),
      .hopper_ack(hopper_ack), .refill(refill), .refill_sel(refill_sel),
      .busy(busy_a), .done(done_a), .short_amount(short_a), .fault(fault_a),
      .inv_rs10(inv10_a), .inv_rs5(inv5_a), .inv_rs2(inv2_a), .inv_rs1(inv1_a)
   );

   change_payout_sequencer #(.INIT_RS10(0), .INIT_RS5(1), .INIT_RS2(0), .INIT_RS1(2)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_amount(req_amount),
      .req_ready(ready_b), .hopper_fire(fire_b), .hopper_sel(sel_b),
      .hopper_ack(hopper_ack), .refill(refill), .refill_sel(refill_sel),
      .busy(busy_b), .done(done_b), .short_amount(short_b), .fault(fault_b),
      .inv_rs10(inv10_b), .inv_rs5(inv5_b), .inv_rs2(inv2_b), .inv_rs1(inv1_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Hopper model: ack two cycles after each fire, optionally with a same-cycle Rs5 refill.
   always @(negedge clk) begin
      if (rst) begin
         rsp_cnt = 0; rsp_ack = 1'b0; rsp_refill = 1'b0;
      end else begin
         rsp_ack = 1'b0; rsp_refill = 1'b0;
         if (rsp_cnt == 1) begin
            rsp_ack = 1'b1; rsp_refill = refill_with_ack; rsp_cnt = 0;
         end else if (rsp_cnt == 2) begin
            rsp_cnt = 1;
         end
         if (auto_ack && (fire_a || fire_b)) rsp_cnt = 2;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (fire_a) begin
            if (exp_sel_a.size() == 0) check("a_fire_extra", fire_a, 0);
            else check("a_fire_sel", sel_a, exp_sel_a.pop_front());
         end
         if (done_a) begin
            if (exp_short_a.size() == 0) check("a_done_extra", done_a, 0);
            else check("a_short", short_a, exp_short_a.pop_front());
         end
         if (fire_b) begin
            if (exp_sel_b.size() == 0) check("b_fire_extra", fire_b, 0);
            else check("b_fire_sel", sel_b, exp_sel_b.pop_front());
         end
         if (done_b) begin
            if (exp_short_b.size() == 0) check("b_done_extra", done_b, 0);
            else check("b_short", short_b, exp_short_b.pop_front());
         end
      end
   end

   task automatic send(input bit to_b, input int amount);
      @(negedge clk);
      req_amount = 5'(amount);
      if (to_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      @(negedge clk);
      req_valid_a = 1'b0; req_valid_b = 1'b0;
   endtask

   task automatic wait_done(input bit on_b, input int budget);
      int n = 0;
      while (!(on_b ? done_b : done_a) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", on_b ? done_b : done_a, 1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic check_idle_a(input string tag, input int exp_inv);
      check({tag, "_ready"}, ready_a, 1);
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_fire"}, fire_a, 0);
      check({tag, "_sel"}, sel_a, 0);
      check({tag, "_done"}, done_a, 0);
      check({tag, "_short"}, short_a, 0);
      check({tag, "_fault"}, fault_a, 0);
      check({tag, "_inv10"}, inv10_a, exp_inv);
      check({tag, "_inv5"}, inv5_a, exp_inv);
      check({tag, "_inv2"}, inv2_a, exp_inv);
      check({tag, "_inv1"}, inv1_a, exp_inv);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_amount = '0;
      tb_ack = 1'b0; tb_refill = 1'b0; tb_refill_sel = '0;
      auto_ack = 1'b1; refill_with_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_a("reset", 8);
      check("reset_b_inv1", inv1_b, 2);
      rst = 1'b0;

      // 18 with full hoppers: one of each coin
      exp_sel_a.push_back(4); exp_sel_a.push_back(3); exp_sel_a.push_back(2); exp_sel_a.push_back(1);
      exp_short_a.push_back(0);
      send(0, 18);
      check("t1_busy_c1", busy_a, 1);
      check("t1_ready_c1", ready_a, 0);
      check("t1_nofire_c1", fire_a, 0);
      @(negedge clk);
      check("t1_fire_c2", fire_a, 1);
      wait_done(0, 80);
      check("t1_inv10", inv10_a, 7); check("t1_inv5", inv5_a, 7);
      check("t1_inv2", inv2_a, 7);   check("t1_inv1", inv1_a, 7);

      // zero amount completes in cycle 1 with no coin
      exp_short_a.push_back(0);
      send(0, 0);
      check("t2_done_c1", done_a, 1);
      @(negedge clk);
      check("t2_ready", ready_a, 1);
      check("t2_inv10", inv10_a, 7); check("t2_inv1", inv1_a, 7);

      // refill and payout of the same counter in one cycle cancel
      do_reset();
      refill_with_ack = 1'b1;
      exp_sel_a.push_back(3); exp_short_a.push_back(0);
      send(0, 5);
      wait_done(0, 40);
      refill_with_ack = 1'b0;
      check("t5_inv5_cancel", inv5_a, 8);
      tb_refill = 1'b1; tb_refill_sel = 3'd6;
      @(negedge clk);
      tb_refill = 1'b0;
      @(negedge clk);
      check("t5_sel6_inv10", inv10_a, 8); check("t5_sel6_inv5", inv5_a, 8);
      check("t5_sel6_inv2", inv2_a, 8);   check("t5_sel6_inv1", inv1_a, 8);
      tb_refill = 1'b1; tb_refill_sel = 3'd4;
      repeat (60) @(negedge clk);
      tb_refill = 1'b0;
      @(negedge clk);
      check("t5_saturate", inv10_a, 63);

      // reset during WAIT_ACK of a 12 payout
      do_reset();
      auto_ack = 1'b0;
      exp_sel_a.push_back(4);
      send(0, 12);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle_a("t6_abort", 8);
      rst = 1'b0;

`ifdef PAYOUT_TIMEOUT_EN
      begin
         int n = 0;
         exp_sel_a.push_back(3);
         send(0, 5);
         @(negedge clk);
         while (!fault_a && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("t4_fault_cycle", n, 16);
         check("t4_fault", fault_a, 1);
         check("t4_short", short_a, 5);
         check("t4_ready", ready_a, 0);
         check("t4_busy", busy_a, 1);
         check("t4_inv5", inv5_a, 8);
         do_reset();
         check("t4_rst_fault", fault_a, 0);
         check("t4_rst_ready", ready_a, 1);
         check("t4_rst_short", short_a, 0);
      end
`else
      exp_sel_a.push_back(3); exp_short_a.push_back(0);
      send(0, 5);
      repeat (40) @(negedge clk);
      check("t4_nofault", fault_a, 0);
      check("t4_still_busy", busy_a, 1);
      tb_ack = 1'b1;
      @(negedge clk);
      tb_ack = 1'b0;
      wait_done(0, 10);
      check("t4_inv5", inv5_a, 7);
      do_reset();
`endif

      // sparse inventory: 9 pays 5,1,1 and leaves 2
      auto_ack = 1'b1;
      exp_sel_b.push_back(3); exp_sel_b.push_back(1); exp_sel_b.push_back(1);
      exp_short_b.push_back(2);
      send(1, 9);
      wait_done(1, 80);
      check("t3_inv5", inv5_b, 0);
      check("t3_inv1", inv1_b, 0);

      // greedy without backtracking: 6 with one Rs5 and three Rs2 leaves 1
      tb_refill = 1'b1; tb_refill_sel = 3'd3;
      @(negedge clk);
      tb_refill_sel = 3'd2;
      repeat (3) @(negedge clk);
      tb_refill = 1'b0;
      exp_sel_b.push_back(3); exp_short_b.push_back(1);
      send(1, 6);
      wait_done(1, 40);
      check("greedy_inv2", inv2_b, 3);
      check("greedy_inv5", inv5_b, 0);

      repeat (3) @(negedge clk);
      check("sb_a_left", exp_sel_a.size() + exp_short_a.size(), 0);
      check("sb_b_left", exp_sel_b.size() + exp_short_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
